// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer: picks the next PC (jump > branch > PC+4),
// drives the instruction-memory request/ready handshake and hands one instruction at a time to IF/ID.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemReady,
    input  logic [31:0]       ImemData,
    output logic [ADDR_W-1:0] PCResult,
    output logic              InstrValid,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] InstrPC
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              discard_fetch;

    // Jump wins over branch; targets are always word aligned.
    assign redirect        = Jump | BranchTaken;
    assign redirect_target = (Jump ? JumpTarget : BranchTarget) & ~ADDR_W'(3);
    assign discard_fetch   = pend_valid | redirect;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   if (ImemReady && !discard_fetch) state_next = DELIVER;
            DELIVER: if (redirect || !Stall) state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        ImemReq    = (state == FETCH);
        ImemAddr   = pc;
        PCResult   = pc;
        InstrValid = instr_valid;
        Instr      = instr;
        InstrPC    = instr_pc;
    end

    // A redirect seen mid-request is parked in pend_target so the outstanding address stays stable;
    // the word that eventually returns for that request is dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc          <= RESET_VECTOR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (redirect) pc <= redirect_target;
                end
                FETCH: begin
                    if (ImemReady) begin
                        if (discard_fetch) begin
                            pc         <= redirect ? redirect_target : pend_target;
                            pend_valid <= 1'b0;
                        end else begin
                            instr       <= ImemData;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + ADDR_W'(4);
                        end
                    end else if (redirect) begin
                        pend_valid  <= 1'b1;
                        pend_target <= redirect_target;
                    end
                end
                DELIVER: begin
                    if (redirect) begin
                        pc          <= redirect_target;
                        instr_valid <= 1'b0;
                    end else if (!Stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, stall, redirect priority,
// redirect during a wait, PC wrap and reset in mid-fetch, all with hand-computed expectations.
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic [31:0] PCResult;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemData(ImemData),
        .PCResult(PCResult), .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0; ImemReady = 1'b1; ImemData = 32'hFFFF_FFFF;
        tick(); tick();
        checks++; if (PCResult !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp %h", PCResult, 32'h0); end
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b exp 0", ImemReq); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", InstrValid); end
        checks++; if (Instr !== 32'h0 || InstrPC !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h/%h exp 0/0", Instr, InstrPC); end
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
        for (int k = 0; k < 3; k++) begin
            ImemData = words[k];
            tick();
            checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'(4*k)) begin errors++; $display("[TB] FAIL seq_req%0d got %b/%h exp 1/%h", k, ImemReq, ImemAddr, 32'(4*k)); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("[TB] FAIL seq_gap%0d got %b exp 0", k, InstrValid); end
            tick();
            checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'(4*k) || Instr !== words[k]) begin errors++; $display("[TB] FAIL seq_dlv%0d got %b/%h/%h exp 1/%h/%h", k, InstrValid, InstrPC, Instr, 32'(4*k), words[k]); end
            checks++; if (ImemReq !== 1'b0 || PCResult !== 32'(4*k+4)) begin errors++; $display("[TB] FAIL seq_pc%0d got %b/%h exp 0/%h", k, ImemReq, PCResult, 32'(4*k+4)); end
        end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (ImemAddr !== 32'hC || ImemReq !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre got %b/%h exp 1/0000000c", ImemReq, ImemAddr); end
        ImemData = 32'h2002_000A;
        Stall = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (InstrValid !== 1'b1 || Instr !== 32'h2002_000A || InstrPC !== 32'hC || PCResult !== 32'h10 || ImemReq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got v%b i%h ipc%h pc%h req%b exp v1 i2002000a ipc0000000c pc00000010 req0", c, InstrValid, Instr, InstrPC, PCResult, ImemReq);
            end
            if (c < 2) tick();
        end
        Stall = 1'b0;
        tick();
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h10) begin errors++; $display("[TB] FAIL stall_release got v%b req%b a%h exp v0 req1 a00000010", InstrValid, ImemReq, ImemAddr); end
        ImemData = 32'h1111_1111;
        tick();
        checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h10 || PCResult !== 32'h14) begin errors++; $display("[TB] FAIL stall_next got v%b ipc%h pc%h exp v1 ipc00000010 pc00000014", InstrValid, InstrPC, PCResult); end
    endtask

    task automatic test_redirect_priority();
        Jump = 1'b1; JumpTarget = 32'h40; BranchTaken = 1'b1; BranchTarget = 32'h80;
        tick();
        Jump = 1'b0; BranchTaken = 1'b0;
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin errors++; $display("[TB] FAIL prio_jump got v%b req%b a%h exp v0 req1 a00000040", InstrValid, ImemReq, ImemAddr); end
        ImemData = 32'h2222_2222;
        tick();
        checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h40 || PCResult !== 32'h44) begin errors++; $display("[TB] FAIL prio_fetch got v%b ipc%h pc%h exp v1 ipc00000040 pc00000044", InstrValid, InstrPC, PCResult); end
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
        tick();
        BranchTaken = 1'b0; Stall = 1'b0;
        checks++; if (InstrValid !== 1'b0 || ImemAddr !== 32'h80 || ImemReq !== 1'b1) begin errors++; $display("[TB] FAIL flush_stalled got v%b req%b a%h exp v0 req1 a00000080", InstrValid, ImemReq, ImemAddr); end
        ImemData = 32'h3333_3333;
        tick();
        checks++; if (InstrPC !== 32'h80 || Instr !== 32'h3333_3333 || PCResult !== 32'h84) begin errors++; $display("[TB] FAIL flush_fetch got ipc%h i%h pc%h exp ipc00000080 i33333333 pc00000084", InstrPC, Instr, PCResult); end
    endtask

    task automatic test_branch_wait();
        ImemReady = 1'b0;
        tick();
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        for (int c = 0; c < 3; c++) begin
            checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h84 || InstrValid !== 1'b0) begin errors++; $display("[TB] FAIL wait_hold%0d got req%b a%h v%b exp req1 a00000084 v0", c, ImemReq, ImemAddr, InstrValid); end
            tick();
            BranchTaken = 1'b0;
        end
        ImemReady = 1'b1; ImemData = 32'hDEAD_BEEF;
        tick();
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin errors++; $display("[TB] FAIL wait_drop got v%b req%b a%h exp v0 req1 a00000100", InstrValid, ImemReq, ImemAddr); end
        ImemData = 32'h4444_4444;
        tick();
        checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || Instr !== 32'h4444_4444) begin errors++; $display("[TB] FAIL wait_target got v%b ipc%h i%h exp v1 ipc00000100 i44444444", InstrValid, InstrPC, Instr); end
    endtask

    task automatic test_wrap_and_align();
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        tick();
        Jump = 1'b0;
        checks++; if (ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr got %h exp fffffffc", ImemAddr); end
        ImemData = 32'h5555_5555;
        tick();
        checks++; if (PCResult !== 32'h0 || InstrPC !== 32'hFFFF_FFFC || InstrValid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pc got pc%h ipc%h v%b exp pc00000000 ipcfffffffc v1", PCResult, InstrPC, InstrValid); end
        Jump = 1'b1; JumpTarget = 32'h43;
        tick();
        Jump = 1'b0;
        checks++; if (ImemAddr !== 32'h40 || ImemReq !== 1'b1) begin errors++; $display("[TB] FAIL align got req%b a%h exp req1 a00000040", ImemReq, ImemAddr); end
        BranchTaken = 1'b1; BranchTarget = 32'h200; ImemData = 32'h6666_6666;
        tick();
        BranchTaken = 1'b0;
        checks++; if (InstrValid !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin errors++; $display("[TB] FAIL same_cycle got v%b req%b a%h exp v0 req1 a00000200", InstrValid, ImemReq, ImemAddr); end
        ImemData = 32'h7777_7777;
        tick();
        checks++; if (InstrPC !== 32'h200 || Instr !== 32'h7777_7777) begin errors++; $display("[TB] FAIL same_next got ipc%h i%h exp ipc00000200 i77777777", InstrPC, Instr); end
    endtask

    task automatic test_reset_mid_fetch();
        ImemReady = 1'b0;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h204) begin errors++; $display("[TB] FAIL rst_pre got req%b a%h exp req1 a00000204", ImemReq, ImemAddr); end
        Reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h300;
        tick();
        Reset = 1'b0; BranchTaken = 1'b0;
        checks++; if (PCResult !== 32'h0 || ImemReq !== 1'b0 || InstrValid !== 1'b0 || InstrPC !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid got pc%h req%b v%b ipc%h exp 0/0/0/0", PCResult, ImemReq, InstrValid, InstrPC); end
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin errors++; $display("[TB] FAIL rst_boot got req%b a%h exp req1 a00000000", ImemReq, ImemAddr); end
        ImemReady = 1'b1; ImemData = 32'h8888_8888;
        tick();
        checks++; if (InstrValid !== 1'b1 || InstrPC !== 32'h0 || PCResult !== 32'h4) begin errors++; $display("[TB] FAIL rst_nopend got v%b ipc%h pc%h exp v1 ipc00000000 pc00000004", InstrValid, InstrPC, PCResult); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_priority();
        test_branch_wait();
        test_wrap_and_align();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
